// File: rtl/serial_frame_scheduler_if.sv
// Bundle between the requesters/one-pulser and the serial frame scheduler.
// Latency: none, this is wiring only. Backpressure: none here; the scheduler paces bits with clkEn.
// master: drives clkEn, req, len0/1 and serIn0/1, and receives gnt, bitAdv, serOut/serOutValid, Count, done and aborted.
// slave: the scheduler side of the same signals.
interface serial_frame_scheduler_if #(
  parameter int CNT_W = 4
);
  logic             clkEn;
  logic [1:0]       req;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic             serIn0;
  logic             serIn1;
  logic [1:0]       gnt;
  logic [1:0]       bitAdv;
  logic             serOut;
  logic             serOutValid;
  logic [CNT_W-1:0] Count;
  logic             done;
  logic             aborted;

  modport master (
    output clkEn, req, len0, len1, serIn0, serIn1,
    input  gnt, bitAdv, serOut, serOutValid, Count, done, aborted
  );

  modport slave (
    input  clkEn, req, len0, len1, serIn0, serIn1,
    output gnt, bitAdv, serOut, serOutValid, Count, done, aborted
  );
endinterface

// File: rtl/serial_frame_scheduler.sv
// Round-robin scheduler that lends the single serial output path to one of two requesters for one frame at a time.
// Latency: req->gnt 1 cycle, gnt->Count loaded 1 cycle, clkEn->serOut/serOutValid/bitAdv 1 cycle. All outputs are registered.
// Backpressure: each bit waits for a clkEn strobe. A requester dropping req aborts its frame.
// Ports: clk and rst (async, active high). bus (slave modport) carries clkEn, req[1:0], len0/len1, serIn0/serIn1 in,
//        and gnt[1:0], bitAdv[1:0], serOut, serOutValid, Count, done and aborted out.
// Optional: define SFS_TIMEOUT_EN to add a watchdog that aborts a frame after TIMEOUT cycles without clkEn.
module serial_frame_scheduler #(
  parameter int CNT_W = 4
`ifdef SFS_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic                 clk,
  input logic                 rst,
  serial_frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;       // index of the channel served most recently
  logic [CNT_W-1:0] count_q, count_d;
  logic             ser_out_q, ser_out_d;
  logic             valid_q, valid_d;
  logic [1:0]       adv_q, adv_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

`ifdef SFS_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // The granted channel's inputs. gnt is one-hot, so bit 1 alone identifies the channel.
  logic             sel_ch;
  logic [CNT_W-1:0] sel_len;
  logic             sel_ser;
  logic             sel_req;

  assign sel_ch  = gnt_q[1];
  assign sel_len = sel_ch ? bus.len1   : bus.len0;
  assign sel_ser = sel_ch ? bus.serIn1 : bus.serIn0;
  assign sel_req = sel_ch ? bus.req[1] : bus.req[0];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    count_d   = count_q;
    ser_out_d = ser_out_q;
    valid_d   = 1'b0;
    adv_d     = 2'b00;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef SFS_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // A tie goes to the channel that was not served last.
          if (bus.req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else                  gnt_d = bus.req;
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = sel_len;
`ifdef SFS_TIMEOUT_EN
        idle_d  = '0;
`endif
        if (sel_len == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.clkEn) begin
          // A strobe is honoured even when req drops in the same cycle; the abort follows next cycle.
          ser_out_d = sel_ser;
          valid_d   = 1'b1;
          adv_d     = gnt_q;
`ifdef SFS_TIMEOUT_EN
          idle_d    = '0;
`endif
          if (count_q != '0) count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (!sel_req) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
`ifdef SFS_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;   // channel 0 wins the first tie
      count_q   <= '0;
      ser_out_q <= 1'b0;
      valid_q   <= 1'b0;
      adv_q     <= 2'b00;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef SFS_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      count_q   <= count_d;
      ser_out_q <= ser_out_d;
      valid_q   <= valid_d;
      adv_q     <= adv_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef SFS_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.bitAdv      = adv_q;
  assign bus.serOut      = ser_out_q;
  assign bus.serOutValid = valid_q;
  assign bus.Count       = count_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Bench for serial_frame_scheduler: a frame-level model predicts each frame's per-cycle outputs.
// Latency: n/a. Backpressure: the bench paces bits through clkEn and drops req to abort frames.
module tb_serial_frame_scheduler;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  serial_frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

  serial_frame_scheduler #(
    .CNT_W(CNT_W)
`ifdef SFS_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected per-cycle trace of the current frame; index = edge number counted from the edge that samples req.
  logic [1:0] e_gnt  [0:63];
  logic [1:0] e_adv  [0:63];
  int         e_cnt  [0:63];
  logic       e_vld  [0:63];
  logic       e_sout [0:63];
  logic       e_done [0:63];
  logic       e_abt  [0:63];
  int         cyc      = -1;
  int         chk_last = -1;
  bit         chk_on   = 1'b0;

  // Model state carried between frames.
  int   m_last  = 1;
  int   m_count = 0;
  logic m_sout  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_count = 0;
    m_sout  = 1'b0;
  endtask

  // ce[e] = clkEn at edge e; drop = first edge with req[g] low (-1: held until done).
  task automatic run_frame(input logic [1:0] reqm, input int len, input logic [15:0] bits,
                           input logic [63:0] ce, input int drop,
                           output int g_o, output int d_o, output bit ab_o);
    int         g, d, acc, kd, left;
    bit         ab;
    logic [63:0] accm;
    logic [1:0] oh;
    logic       so;
    // Round-robin: a tie goes to the channel not served last.
    if (reqm == 2'b11) g = (m_last == 1) ? 0 : 1;
    else               g = (reqm == 2'b10) ? 1 : 0;
    oh   = (g == 0) ? 2'b01 : 2'b10;
    acc  = 0;
    d    = -1;
    ab   = 1'b0;
    accm = '0;
    // Bits are taken from edge 2 on (req->gnt, then LOAD); the frame ends on the len-th
    // accepted strobe, or at the first strobe-less edge once req is gone.
    if (len == 0) d = 1;
    else begin
      for (int e = 2; e < 60; e++) begin
        if (d < 0) begin
          if (ce[e]) begin
            accm[e] = 1'b1;
            acc++;
            if (acc == len) d = e;
          end else if (drop >= 0 && e >= drop) begin
            d  = e;
            ab = 1'b1;
          end
        end
      end
    end
    if (d < 0) begin
      $display("FAIL frame_setup: stimulus never ends the frame");
      $fatal(1);
    end
    so   = m_sout;
    left = len;
    acc  = 0;
    for (int c = 0; c <= d + 1; c++) begin
      e_vld[c] = 1'b0;
      e_adv[c] = 2'b00;
      if (accm[c]) begin
        so = bits[acc];
        acc++;
        left--;
        e_vld[c] = 1'b1;
        e_adv[c] = oh;
      end
      e_sout[c] = so;
      e_cnt[c]  = (c == 0) ? m_count : left;
      e_gnt[c]  = (c <= d) ? oh : 2'b00;
      e_done[c] = (c == d);
      e_abt[c]  = (c == d) && ab;
    end
    chk_last = d + 1;
    chk_on   = 1'b1;
    kd       = 0;
    for (int e = 0; e <= d + 1; e++) begin
      bus.req = reqm;
      if ((drop >= 0 && e >= drop) || e > d) bus.req[g] = 1'b0;
      bus.clkEn = ce[e];
      if (g == 0) begin
        bus.serIn0 = bits[kd];
        bus.serIn1 = ~bits[kd];
        bus.len0   = CNT_W'(len);
        bus.len1   = ~CNT_W'(len);
      end else begin
        bus.serIn1 = bits[kd];
        bus.serIn0 = ~bits[kd];
        bus.len1   = CNT_W'(len);
        bus.len0   = ~CNT_W'(len);
      end
      @(posedge clk);
      cyc = e;
      if (accm[e]) kd++;
      #1;
    end
    @(negedge clk);
    #1;
    chk_on    = 1'b0;
    cyc       = -1;
    bus.clkEn = 1'b0;
    m_last    = g;
    m_count   = len - acc;
    m_sout    = so;
    g_o  = g;
    d_o  = d;
    ab_o = ab;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req   = 2'b00;
    bus.clkEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  int g, d, first_done;
  bit ab, first_abt;

  initial begin
    // Compare process: checks every output against the model trace on each cycle of a frame.
    fork
      begin
        forever begin
          @(negedge clk);
          if (chk_on && cyc >= 0 && cyc <= chk_last) begin
            chk($sformatf("c%0d gnt", cyc),         bus.gnt,         e_gnt[cyc]);
            chk($sformatf("c%0d bitAdv", cyc),      bus.bitAdv,      e_adv[cyc]);
            chk($sformatf("c%0d serOutValid", cyc), bus.serOutValid, e_vld[cyc]);
            chk($sformatf("c%0d serOut", cyc),      bus.serOut,      e_sout[cyc]);
            chk($sformatf("c%0d Count", cyc),       bus.Count,       e_cnt[cyc]);
            chk($sformatf("c%0d done", cyc),        bus.done,        e_done[cyc]);
            chk($sformatf("c%0d aborted", cyc),     bus.aborted,     e_abt[cyc]);
          end
        end
      end
    join_none

    rst = 1'b1;
    bus.req    = 2'b00;
    bus.clkEn  = 1'b0;
    bus.len0   = '0;
    bus.len1   = '0;
    bus.serIn0 = 1'b0;
    bus.serIn1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", {bus.gnt, bus.bitAdv, bus.serOut, bus.serOutValid, bus.Count, bus.done, bus.aborted}, 0);
    rst = 1'b0;
    #1;
    model_reset();

    // Single frame: 3 bits 1,0,1 on channel 0, strobes on consecutive edges.
    run_frame(2'b01, 3, 16'b101, 64'b11100, -1, g, d, ab);
    chk("f1 grant ch", g, 0);
    chk("f1 done edge", d, 4);
    chk("f1 aborted", ab, 0);
    chk("f1 Count held", bus.Count, 0);
    chk("f1 gnt idle", bus.gnt, 0);

    // Round-robin from reset with both channels requesting, frames back-to-back.
    do_reset();
    run_frame(2'b11, 2, 16'b10, 64'b10100, -1, g, d, ab);
    chk("rr1 grant ch", g, 0);
    chk("rr1 done edge", d, 4);
    run_frame(2'b11, 4, 16'b0110, 64'b1101100, -1, g, d, ab);
    chk("rr2 grant ch", g, 1);
    chk("rr2 done edge", d, 6);
    run_frame(2'b11, 1, 16'b1, 64'b1000, -1, g, d, ab);
    chk("rr3 grant ch", g, 0);
    chk("rr3 done edge", d, 3);

    // Abort: len0=5, req[0] dropped after two strobes.
    run_frame(2'b01, 5, 16'b00011, 64'b1100, 4, g, d, ab);
    chk("ab1 done edge", d, 4);
    chk("ab1 aborted", ab, 1);
    chk("ab1 Count held", bus.Count, 3);

    // Strobe and req drop in the same cycle: bit forwarded, abort on the next edge.
    run_frame(2'b10, 4, 16'b1010, 64'b1100, 3, g, d, ab);
    chk("ab2 done edge", d, 4);
    chk("ab2 aborted", ab, 1);
    chk("ab2 Count held", bus.Count, 2);

    // Zero-length frame on channel 1.
    run_frame(2'b10, 0, 16'b0, 64'b0, -1, g, d, ab);
    chk("z grant ch", g, 1);
    chk("z done edge", d, 1);
    chk("z Count", bus.Count, 0);

    // Asynchronous reset in the middle of a transfer with Count=2.
    bus.req    = 2'b01;
    bus.len0   = 4'd4;
    bus.serIn0 = 1'b1;
    bus.clkEn  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.clkEn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.clkEn = 1'b0;
    chk("pre-reset Count", bus.Count, 2);
    chk("pre-reset serOutValid", bus.serOutValid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {bus.gnt, bus.bitAdv, bus.serOut, bus.serOutValid, bus.Count, bus.done, bus.aborted}, 0);
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    run_frame(2'b11, 2, 16'b01, 64'b1100, -1, g, d, ab);
    chk("post-reset grant ch", g, 0);
    chk("post-reset done edge", d, 3);

    // Granted frame that never sees a strobe.
    bus.req   = 2'b01;
    bus.len0  = 4'd4;
    bus.clkEn = 1'b0;
    first_done = -1;
    first_abt  = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done && first_done < 0) begin
        first_done = e;
        first_abt  = bus.aborted;
      end
    end
`ifdef SFS_TIMEOUT_EN
    chk("timeout done edge", first_done, 10);
    chk("timeout aborted", first_abt, 1);
`else
    chk("no watchdog done", first_done, 32'hFFFF_FFFF);
    chk("no watchdog gnt", bus.gnt, 2'b01);
    chk("no watchdog Count", bus.Count, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_frame_scheduler.md
# serial_frame_scheduler

Controller that shares the lab's single serial output path (serOut/serOutValid plus the bit down-counter feeding the 7-segment display) between two serial requesters. It arbitrates round-robin between the requesters and grants one frame at a time. For the granted frame it loads the length counter and forwards exactly that many bits, one per debounced push-button strobe (clkEn from the one-pulser). It sits between the one-pulser/requesters and the Binary_To_7Segment display inside top.

## Interface
- CNT_W, 4, width of frame length and remaining-bit counter
- TIMEOUT, 255, clk cycles without clkEn before a transfer is aborted (only with SFS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clkEn  in  1  one-cycle bit strobe from one-pulser
- req  in  2  per-channel frame request, level, held until done
- len0  in  CNT_W  channel 0 frame length in bits
- len1  in  CNT_W  channel 1 frame length in bits
- serIn0  in  1  channel 0 serial data bit
- serIn1  in  1  channel 1 serial data bit
- gnt  out  2  one-hot grant, 0 when idle
- bitAdv  out  2  one-cycle pulse to granted channel: bit consumed, present next
- serOut  out  1  forwarded data bit
- serOutValid  out  1  one-cycle qualifier for serOut
- Count  out  CNT_W  remaining bits of current frame, to 7-seg
- done  out  1  one-cycle pulse at end of frame
- aborted  out  1  with done: frame ended early

## Operation
- States: IDLE, LOAD, XFER, DONE.
- IDLE:
  - If req≠0, select a winner and register gnt. Go to LOAD.
  - Round-robin: if both request, grant the channel ≠ last. Otherwise grant the sole requester.
- LOAD:
  - Count ← len of the granted channel.
  - If that len = 0, go to DONE with aborted=0 and emit no bits. Otherwise go to XFER.
- XFER, on clkEn=1 (registered, takes effect next edge):
  - serOut ← serIn of the granted channel.
  - serOutValid ← 1.
  - bitAdv[g] ← 1.
  - Count ← Count−1.
  - If Count was 1, go to DONE.
- XFER, req[g]=0 with no clkEn in the same cycle: go to DONE with aborted=1. No further bits.
- XFER, clkEn and req[g] drop in the same cycle: the bit is forwarded, then the frame aborts.
- DONE:
  - done=1 for one cycle; aborted is valid in the same cycle.
  - last ← g. gnt ← 0. Go to IDLE.
- Count holds its value after DONE until the next LOAD, so the display keeps the final value (0 on normal completion).
- Count never wraps. Decrement happens only in XFER while Count>0.
- clkEn in IDLE, LOAD or DONE is ignored.

## Timing
- Reset values:
  - state=IDLE, gnt=0, bitAdv=0, serOut=0, serOutValid=0, Count=0, done=0, aborted=0.
  - last=1, so channel 0 wins the first tie.
- All outputs are registered.
- req→gnt: 1 cycle.
- gnt→Count loaded: 1 cycle (LOAD).
- clkEn→serOutValid/bitAdv: 1 cycle.
- serOutValid, bitAdv and done are high for exactly one cycle each.
- Minimum frame for L bits, back-to-back clkEn: 2 + L + 1 cycles from req to done.
- Back-to-back frames: IDLE re-arbitrates in the cycle after DONE.
- Reset mid-transfer clears everything immediately (asynchronous). No done pulse is emitted.

## Configuration
- SFS_TIMEOUT_EN defined:
  - An idle counter of width clog2(TIMEOUT+1) runs in XFER and clears on every clkEn.
  - On reaching TIMEOUT it forces DONE with aborted=1.
- SFS_TIMEOUT_EN undefined: no watchdog. A frame waits for clkEn indefinitely.

## Test plan
- Reset, then req=01, len0=3, serIn0=1,0,1 across three clkEn:
  - serOut=1,0,1, each with a 1-cycle serOutValid.
  - Count 3→2→1→0.
  - done=1, aborted=0, gnt=00.
- req=11 from reset:
  - First grant is gnt=01.
  - After done, gnt=10 with no intervening IDLE wait beyond one cycle.
  - Third frame grants 01 again.
- len1=0, req=10: gnt=10, LOAD, done pulse, zero serOutValid pulses, Count=0.
- len0=5; drop req[0] after 2 clkEn:
  - Exactly 2 valid bits.
  - done=1 with aborted=1, Count=3 held.
- Assert rst during XFER with Count=2: all outputs 0 asynchronously, state IDLE.
- With SFS_TIMEOUT_EN, TIMEOUT=8: grant with len0=4 and no clkEn → done with aborted=1 9–10 cycles after entering XFER. Without the macro, the FSM stays in XFER.
